tft_bus_arbiter: RTL and testbench
==================================

Name: tft_bus_arbiter

Overview:
- Shares the single tft_spi byte transmitter between N_REQ drawing engines (init, scene, player, spare).
- Each engine holds req for the whole of its drawing transaction. The arbiter grants exactly one owner at a time and muxes the owner's data/dc/transmit onto the transmitter.
- Non-owners see busy forced high so they stall.
- Replaces the top-level priority-mux glue. Adds round-robin fairness and a stuck-owner watchdog.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- HOLD_LIMIT, 65535, idle cycles an owner may hold the bus without pulsing transmit before it is revoked; 0 disables the watchdog.
- OWN_W, 2, owner index width; must be at least clog2(N_REQ).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  bit i high means requester i wants or holds the bus.
- req_data  in  8*N_REQ  byte from requester i on [8i+7:8i].
- req_dc  in  N_REQ  data/command flag from requester i.
- req_transmit  in  N_REQ  one-cycle send strobe from requester i.
- grant  out  N_REQ  one-hot grant, registered.
- req_busy  out  N_REQ  busy returned to requester i.
- spi_data  out  8  byte to tft_spi.
- spi_dc  out  1  dc to tft_spi.
- spi_transmit  out  1  transmit strobe to tft_spi.
- spi_busy  in  1  busy from tft_spi.
- owner  out  OWN_W  index of current owner; 0 when idle.
- active  out  1  high in GRANT or DRAIN.
- timeout_flag  out  1  sticky; set on a watchdog revoke.

Behaviour:
- Reset values: grant=0, owner=0, active=0, timeout_flag=0, spi_transmit=0, spi_data=0, spi_dc=0, req_busy=all 1, state=IDLE, rr pointer=N_REQ-1, hold counter=0.
- Reset taken mid-transfer: state goes to IDLE at that edge. A tft_spi byte already in flight completes on its own; the arbiter does not wait for it.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - grant=0; every req_busy=1; spi_transmit=0.
  - If any req bit is set, pick the winner and register grant/owner; enter GRANT next edge. Latency from req to grant is 1 cycle.
  - Fixed priority: lowest set index wins.
  - Round-robin: first set index searching from rr+1 upward, wrapping past N_REQ-1 to 0. rr is loaded with the winner index when the grant is issued.
- GRANT:
  - Combinational pass-through from the owner: spi_data=req_data[owner], spi_dc=req_dc[owner], spi_transmit=req_transmit[owner] & req[owner]. Zero added latency, so the tft_spi handshake is unchanged.
  - req_busy[owner]=spi_busy; all other req_busy bits are 1.
  - Transmit strobes from non-owners are ignored and never reach tft_spi.
  - req[owner] falls: go to DRAIN if spi_busy=1, else go to IDLE.
  - Hold counter clears on owner transmit or when spi_busy=1; otherwise it increments.
  - Hold counter reaches HOLD_LIMIT (HOLD_LIMIT≠0): set timeout_flag; go to DRAIN with spi_transmit forced 0 from that cycle on.
- DRAIN:
  - spi_transmit=0; spi_data/spi_dc hold the last owner's values.
  - req_busy for all requesters = 1.
  - Leave to IDLE when spi_busy=0.
- Handover: an owner release followed by a new grant takes at least 2 cycles (the release edge into IDLE, then the grant edge). No cycle ever has two grant bits set.
- A revoked owner that still holds req is treated as a new request in IDLE. In fixed mode it may win again.
- active=1 in GRANT or DRAIN. owner holds its value through DRAIN and returns to 0 in IDLE.
- timeout_flag clears only on rst.

Test Plan:
- Defaults; pulse req[2] at cycle 10 → grant=4'b0100 at cycle 11. Five transmit strobes pass through with spi_data matching req_data[23:16]. req_busy[0,1,3]=1 throughout.
- req=4'b1010 asserted together, RR_MODE=0 → requester 1 granted first. Drop req[1] while spi_busy=0 → IDLE, then grant=4'b1000 two cycles later.
- RR_MODE=1; all four req held, each owner releases after 3 bytes → grant order 0,1,2,3,0.
- Owner 0 drops req while spi_busy=1 for 7 more cycles → DRAIN for those 7 cycles; no grant until spi_busy=0 plus 1 cycle.
- HOLD_LIMIT=20; owner 3 holds req with no transmit and spi_busy=0 → revoked after 20 cycles, timeout_flag=1, spi_transmit stays 0. Transmit from requester 1 while requester 3 owns the bus → spi_transmit stays 0.
- rst asserted in GRANT mid-byte → next edge grant=0, req_busy=4'b1111, timeout_flag=0. After rst deasserts, the first grant goes to requester 0 in both modes.

Source files
------------

// File: rtl/tft_bus_arbiter.sv
// tft_bus_arbiter
//   Shares one tft_spi byte transmitter between N_REQ drawing engines.
//   An engine holds req for its whole transaction. One owner is granted at a
//   time and its data/dc/transmit are passed combinationally to tft_spi.
//   Everyone else sees busy high and stalls. Arbitration is either fixed
//   priority (lowest index wins) or round-robin. A watchdog revokes an owner
//   that holds the bus too long without sending anything.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req[N_REQ]          request/hold per engine
//   req_data[8*N_REQ]   byte per engine, engine i on [8i+7:8i]
//   req_dc[N_REQ]       data/command flag per engine
//   req_transmit[N_REQ] one-cycle send strobe per engine
//   grant[N_REQ]        registered one-hot grant
//   req_busy[N_REQ]     busy back to each engine
//   spi_data/dc/transmit  to tft_spi
//   spi_busy            from tft_spi
//   owner               current owner index, 0 when idle
//   active              bus is in GRANT or DRAIN
//   timeout_flag        sticky watchdog-revoke indicator
module tft_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int RR_MODE    = 0,
  parameter int HOLD_LIMIT = 65535,
  parameter int OWN_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_dc,
  input  logic [N_REQ-1:0]     req_transmit,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     req_busy,
  output logic [7:0]           spi_data,
  output logic                 spi_dc,
  output logic                 spi_transmit,
  input  logic                 spi_busy,
  output logic [OWN_W-1:0]     owner,
  output logic                 active,
  output logic                 timeout_flag
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  localparam int HW = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;

  state_t           state, state_d;
  logic [OWN_W-1:0] rr;
  logic [OWN_W-1:0] win_idx;
  logic             win_vld;
  logic [HW-1:0]    hold_cnt;
  logic [7:0]       data_q;
  logic             dc_q;
  logic             own_req, own_tx, own_dc;
  logic [7:0]       own_data;
  logic             revoke;

  // Winner search. Round-robin starts one past the last winner and wraps.
  always_comb begin : pick
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (RR_MODE != 0) ? (int'(rr) + 1 + k) % N_REQ : k;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = OWN_W'(idx);
      end
    end
  end

  assign own_req  = req[owner];
  assign own_tx   = req_transmit[owner];
  assign own_dc   = req_dc[owner];
  assign own_data = req_data[8*int'(owner) +: 8];
  assign revoke   = (HOLD_LIMIT != 0) && (hold_cnt == HW'(HOLD_LIMIT));
  assign active   = (state != IDLE);

  // Only the owner ever sees the real tft_spi busy, and only while granted.
  for (genvar i = 0; i < N_REQ; i++) begin : g_busy
    assign req_busy[i] = (state == GRANT && owner == OWN_W'(i)) ? spi_busy : 1'b1;
  end

  always_comb begin : fsm
    state_d      = state;
    spi_transmit = 1'b0;
    spi_data     = data_q;
    spi_dc       = dc_q;
    case (state)
      IDLE:  if (win_vld) state_d = GRANT;
      GRANT: begin
        spi_data = own_data;
        spi_dc   = own_dc;
        // Release takes precedence over the watchdog.
        if (!own_req)    state_d = spi_busy ? DRAIN : IDLE;
        else if (revoke) state_d = DRAIN;
        else             spi_transmit = own_tx;
      end
      DRAIN: if (!spi_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      owner        <= '0;
      rr           <= OWN_W'(N_REQ - 1);
      hold_cnt     <= '0;
      timeout_flag <= 1'b0;
      data_q       <= '0;
      dc_q         <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (win_vld) begin
            grant <= N_REQ'(1) << win_idx;
            owner <= win_idx;
            rr    <= win_idx;
          end
        end
        GRANT: begin
          // Last values seen while granted are what DRAIN keeps driving.
          data_q <= own_data;
          dc_q   <= own_dc;
          if (own_req && revoke) timeout_flag <= 1'b1;
          if ((own_req && own_tx) || spi_busy) hold_cnt <= '0;
          else if (HOLD_LIMIT != 0)            hold_cnt <= hold_cnt + HW'(1);
          if (state_d != GRANT) begin
            grant <= '0;
            if (state_d == IDLE) owner <= '0;
          end
        end
        DRAIN: if (state_d == IDLE) owner <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Bench for tft_bus_arbiter. A fixed-priority instance (watchdog = 20) and a
// round-robin instance share all inputs; sel picks which one the scoreboard
// and phase checks look at. Expected transmit bytes and grant order are
// queued when stimulus is driven and popped by a negedge monitor.
module tb_tft_bus_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_dc, req_transmit;
  logic [8*N-1:0] req_data;
  logic           spi_busy;

  logic [N-1:0] f_grant, f_busy, r_grant, r_busy;
  logic [7:0]   f_spi_data, r_spi_data;
  logic         f_spi_dc, f_spi_tx, r_spi_dc, r_spi_tx;
  logic [1:0]   f_owner, r_owner;
  logic         f_active, f_to, r_active, r_to;

  always #5 clk = ~clk;

  tft_bus_arbiter #(.N_REQ(N), .RR_MODE(0), .HOLD_LIMIT(20), .OWN_W(2)) u_fix (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_dc(req_dc),
    .req_transmit(req_transmit), .grant(f_grant), .req_busy(f_busy),
    .spi_data(f_spi_data), .spi_dc(f_spi_dc), .spi_transmit(f_spi_tx),
    .spi_busy(spi_busy), .owner(f_owner), .active(f_active), .timeout_flag(f_to));

  tft_bus_arbiter #(.N_REQ(N), .RR_MODE(1), .HOLD_LIMIT(65535), .OWN_W(2)) u_rr (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_dc(req_dc),
    .req_transmit(req_transmit), .grant(r_grant), .req_busy(r_busy),
    .spi_data(r_spi_data), .spi_dc(r_spi_dc), .spi_transmit(r_spi_tx),
    .spi_busy(spi_busy), .owner(r_owner), .active(r_active), .timeout_flag(r_to));

  logic         sel;
  logic [N-1:0] c_grant, c_busy;
  logic [7:0]   c_spi_data;
  logic         c_spi_dc, c_spi_tx, c_active, c_to;
  logic [1:0]   c_owner;
  assign c_grant    = sel ? r_grant    : f_grant;
  assign c_busy     = sel ? r_busy     : f_busy;
  assign c_spi_data = sel ? r_spi_data : f_spi_data;
  assign c_spi_dc   = sel ? r_spi_dc   : f_spi_dc;
  assign c_spi_tx   = sel ? r_spi_tx   : f_spi_tx;
  assign c_active   = sel ? r_active   : f_active;
  assign c_to       = sel ? r_to       : f_to;
  assign c_owner    = sel ? r_owner    : f_owner;

  int           n_vec = 0;
  int           n_err = 0;
  logic         mon_en = 1'b0;
  logic [8:0]   tq[$];
  logic [N-1:0] gq[$];
  logic [N-1:0] g_prev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && c_spi_tx) begin
      if (tq.size() == 0) chk("tx_unexpected", 32'(c_spi_tx), 32'd0);
      else                chk("tx_byte", {c_spi_dc, c_spi_data}, tq.pop_front());
    end
    if (mon_en && c_grant != g_prev && c_grant != '0) begin
      chk("grant_onehot", $countones(c_grant), 1);
      if (gq.size() == 0) chk("grant_unexpected", c_grant, 0);
      else                chk("grant_order", c_grant, gq.pop_front());
    end
    g_prev = c_grant;
  end

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1; req = '0; req_dc = '0; req_transmit = '0; req_data = '0; spi_busy = 1'b0;
    tq.delete(); gq.delete();
    step(); step();
    rst = 1'b0;
  endtask

  // Owner o sends one byte, then tft_spi is busy for one cycle.
  task automatic send_byte(input int o, input logic [7:0] d, input logic dc);
    req_data[8*o +: 8] = d;
    req_dc[o]          = dc;
    req_transmit[o]    = 1'b1;
    tq.push_back({dc, d});
    #1;
    chk("busy_others", c_busy | (4'b0001 << o), 4'hF);
    chk("tx_pass", c_spi_tx, 1);
    step();
    req_transmit[o] = 1'b0;
    spi_busy        = 1'b1;
    #1 chk("busy_own_hi", c_busy[o], 1);
    step();
    spi_busy = 1'b0;
    #1 chk("busy_own_lo", c_busy[o], 0);
  endtask

  initial begin
    sel = 1'b0;
    do_reset();
    // Reset state, both instances.
    chk("rst_grant", f_grant, 0);   chk("rst_owner", f_owner, 0);
    chk("rst_active", f_active, 0); chk("rst_to", f_to, 0);
    chk("rst_tx", f_spi_tx, 0);     chk("rst_data", {f_spi_dc, f_spi_data}, 0);
    chk("rst_busy", f_busy, 4'hF);
    chk("rst_rr_grant", r_grant, 0); chk("rst_rr_busy", r_busy, 4'hF);

    // Single requester 2, five bytes.
    step(); step();
    mon_en = 1'b1;
    gq.push_back(4'b0100);
    req = 4'b0100;
    #1 chk("p1_no_comb_grant", c_grant, 0);
    step();
    chk("p1_grant", c_grant, 4'b0100); chk("p1_owner", c_owner, 2);
    chk("p1_active", c_active, 1);
    for (int b = 0; b < 5; b++) send_byte(2, 8'($urandom_range(0, 255)), b[0]);
    req = '0;
    step();
    chk("p1_rel_grant", c_grant, 0); chk("p1_rel_owner", c_owner, 0);
    chk("p1_rel_active", c_active, 0);
    chk("p1_sb_tx", tq.size(), 0); chk("p1_sb_g", gq.size(), 0);

    // Fixed priority, handover 1 -> 3.
    do_reset();
    mon_en = 1'b1;
    gq.push_back(4'b0010); gq.push_back(4'b1000);
    req = 4'b1010;
    step();
    chk("p2_grant1", c_grant, 4'b0010);
    req[1] = 1'b0;
    step();
    chk("p2_gap", c_grant, 0);
    step();
    chk("p2_grant3", c_grant, 4'b1000); chk("p2_owner3", c_owner, 3);
    req = '0;
    step();
    chk("p2_sb_g", gq.size(), 0);

    // Round-robin, all requesting, three bytes each.
    sel = 1'b1;
    do_reset();
    mon_en = 1'b1;
    gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0100);
    gq.push_back(4'b1000); gq.push_back(4'b0001);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int o, n;
      o = k % 4;
      n = 0;
      while (c_grant == '0 && n < 10) begin step(); n++; end
      chk("p3_grant_wait", 32'(n < 10), 1);
      chk("p3_owner", c_owner, o);
      for (int b = 0; b < 3; b++) send_byte(o, 8'($urandom_range(0, 255)), b[0]);
      req[o] = 1'b0;
      step();
      chk("p3_idle", c_active, 0);
      if (k < 4) req[o] = 1'b1;
    end
    req = '0;
    step();
    chk("p3_sb_tx", tq.size(), 0); chk("p3_sb_g", gq.size(), 0);

    // Release while tft_spi busy: DRAIN.
    sel = 1'b0;
    do_reset();
    mon_en = 1'b1;
    gq.push_back(4'b0001); gq.push_back(4'b0010);
    req = 4'b0001;
    step();
    chk("p4_grant0", c_grant, 4'b0001);
    send_byte(0, 8'h5A, 1'b1);
    req = 4'b0010; spi_busy = 1'b1; req_transmit[0] = 1'b1;
    #1 chk("p4_rel_tx_gated", c_spi_tx, 0);
    step();
    req_transmit[0] = 1'b0;
    req_data[7:0]   = 8'h11;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("p4_drain_active", c_active, 1); chk("p4_drain_grant", c_grant, 0);
      chk("p4_drain_busy", c_busy, 4'hF);  chk("p4_drain_tx", c_spi_tx, 0);
      chk("p4_drain_data", {c_spi_dc, c_spi_data}, {1'b1, 8'h5A});
      if (i == 6) spi_busy = 1'b0;
      step();
    end
    chk("p4_idle_active", c_active, 0); chk("p4_idle_grant", c_grant, 0);
    chk("p4_idle_owner", c_owner, 0);
    step();
    chk("p4_grant1", c_grant, 4'b0010);
    req = '0;
    step();
    chk("p4_sb_tx", tq.size(), 0); chk("p4_sb_g", gq.size(), 0);

    // Watchdog revoke after 20 idle cycles; non-owner strobes blocked.
    do_reset();
    mon_en = 1'b1;
    gq.push_back(4'b1000); gq.push_back(4'b1000);
    req = 4'b1000;
    step();
    for (int c = 1; c <= 21; c++) begin
      chk("p5_hold_active", c_active, 1); chk("p5_hold_grant", c_grant, 4'b1000);
      chk("p5_hold_to", c_to, 0);
      if (c == 5) begin
        req_data[15:8] = 8'hAA; req_transmit[1] = 1'b1;
        #1 chk("p5_nonowner_tx", c_spi_tx, 0);
      end
      if (c == 21) begin
        req_transmit[3] = 1'b1;
        #1 chk("p5_revoke_tx", c_spi_tx, 0);
      end
      step();
      req_transmit = '0;
    end
    chk("p5_to_set", c_to, 1); chk("p5_drain_grant", c_grant, 0);
    chk("p5_drain_active", c_active, 1);
    #1 chk("p5_drain_tx", c_spi_tx, 0);
    step();
    chk("p5_idle_active", c_active, 0); chk("p5_to_sticky", c_to, 1);
    step();
    chk("p5_regrant", c_grant, 4'b1000); chk("p5_to_sticky2", c_to, 1);

    // Reset mid-byte, then first grant after reset in both modes.
    req_data[31:24] = 8'h77; req_transmit[3] = 1'b1;
    tq.push_back({req_dc[3], 8'h77});
    step();
    mon_en = 1'b0;
    req_transmit = '0; spi_busy = 1'b1; req = 4'hF; rst = 1'b1;
    step();
    chk("p6_rst_grant", c_grant, 0); chk("p6_rst_busy", c_busy, 4'hF);
    chk("p6_rst_to", c_to, 0);       chk("p6_rst_active", c_active, 0);
    chk("p6_rst_rr_grant", r_grant, 0);
    chk("p6_sb_tx", tq.size(), 0);
    rst = 1'b0; spi_busy = 1'b0;
    step();
    chk("p6_fix_first", f_grant, 4'b0001);
    chk("p6_rr_first", r_grant, 4'b0001);
    req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

endmodule
